// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
package mdu_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // funct3[2] splits the M-extension into multiply and divide halves
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/mdu_iter_datapath.sv
// Radix-2 multiply/divide datapath: operand latch, one iteration step per
// enable, and sign fix-up of the final value.
module mdu_iter_datapath
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            fast_path,
  output logic [XLEN-1:0] fast_result,
  output logic [XLEN-1:0] final_result
);

  logic [2:0]        op_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q;
  logic              neg_q;
  logic              sign_a_q;

  logic              sign_a_in;
  logic              sign_b_in;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] acc_next;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  logic              div_by_zero;
  logic              div_ovf;

  // Operand signs and magnitudes; MULHSU keeps rs2 unsigned, *U ops keep both unsigned
  always_comb begin
    sign_a_in = src_a[XLEN-1] & (funct3 != F3_MULHU) & (funct3 != F3_DIVU) & (funct3 != F3_REMU);
    sign_b_in = src_b[XLEN-1] & ((funct3 == F3_MUL) | (funct3 == F3_MULH) |
                                 (funct3 == F3_DIV) | (funct3 == F3_REM));
    mag_a     = sign_a_in ? -src_a : src_a;
    mag_b     = sign_b_in ? -src_b : src_b;
  end

  // Divide-by-zero and signed overflow resolve without iterating
  always_comb begin
    div_by_zero = (src_b == '0);
    div_ovf     = ((funct3 == F3_DIV) | (funct3 == F3_REM)) &
                  (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (src_b == '1);
    fast_path   = is_div_op(funct3) & (div_by_zero | div_ovf);
    if (div_by_zero)
      fast_result = funct3[1] ? src_a : '1;
    else
      fast_result = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge   = (rem_sh >= {1'b0, opnd_q});
    div_sub  = rem_sh[XLEN-1:0] - opnd_q;
    if (div_ge)
      div_next = {div_sub, acc_q[XLEN-2:0], 1'b1};
    else
      div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    acc_next = op_q[2] ? div_next : mul_next;
  end

  // Fix-up applies to the post-step value so the result is ready on the last step
  always_comb begin
    prod_fix = neg_q    ? -acc_next : acc_next;
    quo_fix  = neg_q    ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem_fix  = sign_a_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    case (op_q)
      F3_MUL:                       final_result = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_result = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              final_result = quo_fix;
      default:                      final_result = rem_fix;
    endcase
  end

  // Operand and accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= F3_MUL;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
    end else if (load) begin
      op_q     <= funct3;
      neg_q    <= sign_a_in ^ sign_b_in;
      sign_a_q <= sign_a_in;
      if (is_div_op(funct3)) begin
        opnd_q <= mag_b;
        acc_q  <= {{XLEN{1'b0}}, mag_a};
      end else begin
        opnd_q <= mag_a;
        acc_q  <= {{XLEN{1'b0}}, mag_b};
      end
    end else if (step) begin
      acc_q <= acc_next;
    end
  end

endmodule

// File: rtl/mul_div_sequencer.sv
// Execute-stage RV32M sequencer: holds the pipeline while the datapath
// iterates, then presents a registered result for one cycle.
//
//   state | meaning
//   IDLE  | waiting for Start; fast-path ops jump straight to DONE
//   BUSY  | one radix-2 step per cycle, Count counts down to 0
//   DONE  | Done pulse, Result valid, pipeline released
module mul_div_sequencer
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            Flush,
  output logic            StallE,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;
  logic [XLEN-1:0]  result_q;

  logic             load;
  logic             step;
  logic             load_fast;
  logic             load_final;
  logic             fast_path;
  logic [XLEN-1:0]  fast_result;
  logic [XLEN-1:0]  final_result;

  mdu_iter_datapath u_datapath (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .step         (step),
    .funct3       (Funct3),
    .src_a        (SrcA),
    .src_b        (SrcB),
    .fast_path    (fast_path),
    .fast_result  (fast_result),
    .final_result (final_result)
  );

  // Next-state and datapath enables; Flush overrides everything
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    step       = 1'b0;
    load_fast  = 1'b0;
    load_final = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          load = 1'b1;
          if (fast_path) begin
            state_d   = DONE;
            load_fast = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        step = 1'b1;
        if (count_q == '0) begin
          state_d    = DONE;
          load_final = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Flush) begin
      state_d    = IDLE;
      load       = 1'b0;
      step       = 1'b0;
      load_fast  = 1'b0;
      load_final = 1'b0;
    end
  end

  // State, iteration counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (load)
        count_q <= CNT_W'(XLEN - 1);
      else if (step)
        count_q <= count_q - 1'b1;
      if (load_fast)
        result_q <= fast_result;
      else if (load_final)
        result_q <= final_result;
    end
  end

  // Stall covers the accept cycle and the whole BUSY run, released in DONE
  always_comb begin
    StallE = ~rst & (((state_q == IDLE) & Start & ~Flush) | (state_q == BUSY));
    Done   = ~rst & ~Flush & (state_q == DONE);
    Result = result_q;
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Scoreboard bench for mul_div_sequencer.
module tb_mul_div_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        Flush = 1'b0;
  logic        StallE;
  logic        Done;
  logic [31:0] Result;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  mul_div_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .Start  (Start),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Flush  (Flush),
    .StallE (StallE),
    .Done   (Done),
    .Result (Result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sq;
    logic               ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0]; end
      3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'b010: begin p = {{32{a[31]}}, a} * {32'h0, b};       return p[63:32]; end
      3'b011: begin p = {32'h0, a} * {32'h0, b};             return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        sq = $signed(a) / $signed(b);
        return sq;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        sq = $signed(a) % $signed(b);
        return sq;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Called at a negedge: that cycle is cycle 0 of the op. Returns at the negedge after Done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int          lat;
    bit          got;
    logic [31:0] e;
    lat = is_fast(f, a, b) ? 1 : 33;
    exp_q.push_back(exp);
    Funct3 = f; SrcA = a; SrcB = b; Start = 1'b1;
    got = 0;
    for (int c = 0; c <= lat + 4 && !got; c++) begin
      #1;
      n_vec++;
      if (StallE !== (c < lat)) begin
        n_err++;
        $display("FAIL %s stall cycle %0d: got %b want %b", tag, c, StallE, (c < lat));
      end
      n_vec++;
      if (Done !== (c == lat)) begin
        n_err++;
        $display("FAIL %s done cycle %0d: got %b want %b", tag, c, Done, (c == lat));
      end
      if (Done === 1'b1) begin
        got = 1;
        Start = 1'b0;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL %s result: got %h want <no pending result>", tag, Result);
        end else begin
          e = exp_q.pop_front();
          if (Result !== e) begin
            n_err++;
            $display("FAIL %s result: got %h want %h", tag, Result, e);
          end
        end
      end
      @(negedge clk);
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: got no Done want Done at cycle %0d", tag, lat);
      Start = 1'b0;
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; Start = 1'b1; Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd4;
    @(negedge clk); #1;
    n_vec++;
    if (StallE !== 1'b0) begin n_err++; $display("FAIL reset stall: got %b want 0", StallE); end
    @(negedge clk); @(negedge clk); #1;
    n_vec++;
    if (Done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b want 0", Done); end
    n_vec++;
    if (Result !== 32'h0) begin n_err++; $display("FAIL reset result: got %h want 0", Result); end
    Start = 1'b0;
    rst = 1'b0;
    @(negedge clk); #1;
    n_vec++;
    if (StallE !== 1'b0 || Done !== 1'b0) begin
      n_err++; $display("FAIL idle after reset: got stall=%b done=%b want 0 0", StallE, Done);
    end
    @(negedge clk);
  endtask

  task automatic test_spec_vectors();
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3");
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_-1x-1");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_-1xmax");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_-7/2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_-7%2");
    run_op(3'b101, 32'd100, 32'd7, 32'd14, "divu_100/7");
    run_op(3'b111, 32'd100, 32'd7, 32'd2, "remu_100%7");
  endtask

  task automatic test_special();
    run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by_zero");
    run_op(3'b111, 32'd5, 32'd0, 32'd5, "remu_by_zero");
    run_op(3'b100, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, "div_by_zero");
    run_op(3'b110, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, "rem_by_zero");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_overflow");
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "divu_no_overflow");
  endtask

  task automatic test_flush();
    Funct3 = 3'b100; SrcA = 32'd1000; SrcB = 32'd7; Start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_vec++;
      if (Done !== 1'b0) begin n_err++; $display("FAIL flush pre cycle %0d done: got %b want 0", c, Done); end
      @(negedge clk);
    end
    Flush = 1'b1;
    #1;
    n_vec++;
    if (Done !== 1'b0) begin n_err++; $display("FAIL flush cycle10 done: got %b want 0", Done); end
    @(negedge clk);
    Flush = 1'b0; Start = 1'b0;
    #1;
    n_vec++;
    if (StallE !== 1'b0) begin n_err++; $display("FAIL flush cycle11 stall: got %b want 0", StallE); end
    n_vec++;
    if (Done !== 1'b0) begin n_err++; $display("FAIL flush cycle11 done: got %b want 0", Done); end
    @(negedge clk);
    run_op(3'b000, 32'd12345, 32'd678, 32'd8369910, "mul_after_flush");
  endtask

  task automatic test_flush_beats_start();
    Funct3 = 3'b000; SrcA = 32'd9; SrcB = 32'd9; Start = 1'b1; Flush = 1'b1;
    #1;
    n_vec++;
    if (StallE !== 1'b0) begin n_err++; $display("FAIL flush_start stall: got %b want 0", StallE); end
    @(negedge clk);
    Start = 1'b0; Flush = 1'b0;
    #1;
    n_vec++;
    if (StallE !== 1'b0 || Done !== 1'b0) begin
      n_err++; $display("FAIL flush_start idle: got stall=%b done=%b want 0 0", StallE, Done);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid_busy();
    Funct3 = 3'b001; SrcA = 32'h1234_5678; SrcB = 32'h9ABC_DEF0; Start = 1'b1;
    for (int c = 0; c < 5; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    n_vec++;
    if (StallE !== 1'b0 || Done !== 1'b0) begin
      n_err++; $display("FAIL rst_mid stall/done: got %b/%b want 0/0", StallE, Done);
    end
    n_vec++;
    if (Result !== 32'h0) begin n_err++; $display("FAIL rst_mid result: got %h want 0", Result); end
    rst = 1'b0; Start = 1'b0;
    @(negedge clk); #1;
    n_vec++;
    if (StallE !== 1'b0 || Done !== 1'b0) begin
      n_err++; $display("FAIL rst_mid idle: got stall=%b done=%b want 0 0", StallE, Done);
    end
    @(negedge clk);
    run_op(3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, "rem_after_rst");
  endtask

  task automatic test_back_to_back();
    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, "b2b_mul");
    run_op(3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, "b2b_divu0");
    run_op(3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, "b2b_div");
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      f = 3'($urandom_range(0, 7));
      a = (i % 5 == 3) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 50));
        default: b = $urandom;
      endcase
      run_op(f, a, b, ref_model(f, a, b), $sformatf("rand%0d_f%0d", i, f));
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_special();
    test_flush();
    test_flush_beats_start();
    test_rst_mid_busy();
    test_back_to_back();
    test_random();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
